// File: rtl/keccak_squeeze_stream.sv
// rtl/keccak_squeeze_stream.sv - Keccak squeeze end streaming rate bytes as AXI-Stream beats; optional unbounded XOF via SQUEEZE_XOF_STREAM_EN
module keccak_squeeze_stream #(
    parameter int DWIDTH        = 256,
    parameter int LANE_SIZE     = 64,
    parameter int OUT_LEN_WIDTH = 16,
    parameter int KEEP_WIDTH    = DWIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [OUT_LEN_WIDTH-1:0] out_len_i,
    input  logic [25*LANE_SIZE-1:0]  state_i,
    output logic                     perm_req_o,
    input  logic                     perm_done_i,
`ifdef SQUEEZE_XOF_STREAM_EN
    input  logic                     stop_i,
`endif
    output logic [DWIDTH-1:0]        m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     m_axis_tlast_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int STATE_W = 25 * LANE_SIZE;
    localparam int BIDX_W  = $clog2(STATE_W);
    localparam int LW      = OUT_LEN_WIDTH;
    localparam int CW      = $clog2(KEEP_WIDTH + 1);
    localparam logic [LW-1:0] BEAT_BYTES = LW'(KEEP_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUILD     = 2'd1,
        PERM_WAIT = 2'd2,
        OUT       = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [7:0]          ptr_q;        // next unread byte of the rate
    logic [CW-1:0]       carry_q;      // bytes already staged in the current beat
    logic [LW-1:0]       remaining_q;  // output bytes still owed, including staged ones
    logic                unbounded_q;  // XOF stream with no length limit
    logic [DWIDTH-1:0]   tdata_q;
    logic [KEEP_WIDTH-1:0] tkeep_q;
    logic                tlast_q;
    logic                tvalid_q;
    logic                perm_req_q;
    logic                done_q;

    logic [7:0]          rate;
    logic [LW-1:0]       start_len;
    logic                start_unbounded;
    logic                stop_req;
    logic [LW-1:0]       room_beat;
    logic [LW-1:0]       room_rate;
    logic [LW-1:0]       room_len;
    logic [LW-1:0]       take;
    logic [LW-1:0]       fill;
    logic                beat_full;
    logic                beat_end;
    logic                stream_end;
    logic [DWIDTH-1:0]   next_data;
    logic [KEEP_WIDTH-1:0] next_keep;
    logic [BIDX_W-1:0]   bit_idx;

    // Rate of the latched mode and output length / stream kind of the incoming request
    always_comb begin
        case (mode_q)
            2'd0:    rate = 8'd136;
            2'd1:    rate = 8'd72;
            2'd2:    rate = 8'd168;
            default: rate = 8'd136;
        endcase
        case (mode_i)
            2'd0:    start_len = LW'(32);
            2'd1:    start_len = LW'(64);
            default: start_len = out_len_i;
        endcase
`ifdef SQUEEZE_XOF_STREAM_EN
        start_unbounded = mode_i[1] && (out_len_i == '0);
        stop_req        = stop_i;
`else
        start_unbounded = 1'b0;
        stop_req        = 1'b0;
`endif
    end

    // Bytes taken this BUILD cycle: limited by beat space, rate left and output owed
    always_comb begin
        room_beat = BEAT_BYTES - LW'(carry_q);
        room_rate = LW'(rate) - LW'(ptr_q);
        room_len  = unbounded_q ? '1 : (remaining_q - LW'(carry_q));
        take      = room_beat;
        if (room_rate < take) take = room_rate;
        if (room_len < take)  take = room_len;
        fill       = LW'(carry_q) + take;
        beat_full  = (fill == BEAT_BYTES);
        beat_end   = !unbounded_q && (fill == remaining_q);
        stream_end = unbounded_q ? stop_req : (remaining_q == LW'(carry_q));
    end

    // Splice rate bytes ptr.. into beat positions carry..fill-1; a fresh beat starts zeroed
    always_comb begin
        next_data = (carry_q == '0) ? '0 : tdata_q;
        next_keep = '0;
        bit_idx   = '0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            bit_idx = BIDX_W'((int'(ptr_q) + k - int'(carry_q)) * 8);
            if (k >= int'(carry_q) && k < int'(fill))
                next_data[8*k +: 8] = state_i[bit_idx +: 8];
            if (k < int'(fill))
                next_keep[k] = 1'b1;
        end
    end

    // Squeeze control FSM with registered stream and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            ptr_q       <= '0;
            carry_q     <= '0;
            remaining_q <= '0;
            unbounded_q <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            perm_req_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            perm_req_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q      <= mode_i;
                        ptr_q       <= '0;
                        carry_q     <= '0;
                        remaining_q <= start_len;
                        unbounded_q <= start_unbounded;
                        if (start_len == '0 && !start_unbounded)
                            done_q <= 1'b1;
                        else
                            state_q <= BUILD;
                    end
                end
                BUILD: begin
                    tdata_q <= next_data;
                    ptr_q   <= ptr_q + 8'(take);
                    carry_q <= CW'(fill);
                    if (beat_full || beat_end) begin
                        tkeep_q  <= next_keep;
                        tlast_q  <= beat_end;
                        tvalid_q <= 1'b1;
                        state_q  <= OUT;
                    end else begin
                        // rate ran dry mid-beat: keep staged bytes, fetch next block
                        perm_req_q <= 1'b1;
                        state_q    <= PERM_WAIT;
                    end
                end
                PERM_WAIT: begin
                    if (perm_done_i) begin
                        ptr_q   <= '0;
                        state_q <= BUILD;
                    end
                end
                OUT: begin
                    if (m_axis_tready_i) begin
                        tvalid_q <= 1'b0;
                        carry_q  <= '0;
                        if (!unbounded_q)
                            remaining_q <= remaining_q - LW'(carry_q);
                        if (stream_end) begin
                            tlast_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (ptr_q == rate) begin
                            perm_req_q <= 1'b1;
                            state_q    <= PERM_WAIT;
                        end else begin
                            state_q <= BUILD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata_o  = tdata_q;
    assign m_axis_tkeep_o  = tkeep_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tlast_o  = tlast_q | (tvalid_q & unbounded_q & stop_req);
    assign perm_req_o      = perm_req_q;
    assign done_o          = done_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// tb/tb_keccak_squeeze_stream.sv - scoreboard bench for keccak_squeeze_stream
module tb_keccak_squeeze_stream;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [1:0]      mode_i = '0;
    logic [LW-1:0]   out_len_i = '0;
    logic [1599:0]   state_i = '0;
    logic            perm_req;
    logic            perm_done_i = 1'b0;
    logic [DW-1:0]   tdata;
    logic [KW-1:0]   tkeep;
    logic            tvalid;
    logic            tready = 1'b0;
    logic            tlast;
    logic            busy;
    logic            done;
`ifdef SQUEEZE_XOF_STREAM_EN
    logic            stop_i = 1'b0;
`endif

    keccak_squeeze_stream dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .mode_i          (mode_i),
        .out_len_i       (out_len_i),
        .state_i         (state_i),
        .perm_req_o      (perm_req),
        .perm_done_i     (perm_done_i),
`ifdef SQUEEZE_XOF_STREAM_EN
        .stop_i          (stop_i),
`endif
        .m_axis_tdata_o  (tdata),
        .m_axis_tkeep_o  (tkeep),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tready_i (tready),
        .m_axis_tlast_o  (tlast),
        .busy_o          (busy),
        .done_o          (done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t          exp_q[$];
    logic [1599:0]  blocks[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int perm_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int first_valid_cyc = -1;
    int blk_idx = 0;
    int exp_perms = 0;
    int exp_olen = 0;
    int ready_mode = 0;
    bit perm_auto = 1'b1;

    always #5 clk = ~clk;

    task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // sink ready pattern
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: tready = 1'b1;
            1: tready = ~tready;
            2: tready = 1'($urandom);
            default: tready = 1'b0;
        endcase
    end

    // permutation responder: next block appears with perm_done after a short delay
    initial forever begin
        @(negedge clk);
        if (perm_req && perm_auto && !rst) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            blk_idx++;
            if (blk_idx < blocks.size()) state_i = blocks[blk_idx];
            perm_done_i = 1'b1;
            @(posedge clk);
            #1;
            perm_done_i = 1'b0;
        end
    end

    // monitor: pops expected beats on handshake, checks stall stability
    initial begin
        bit              stall_chk;
        logic [DW-1:0]   held_data;
        logic [KW-1:0]   held_keep;
        logic            held_last;
        logic [DW-1:0]   m;
        beat_t           e;
        stall_chk = 1'b0;
        held_data = '0;
        held_keep = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_chk = 1'b0;
            end else begin
                if (perm_req) perm_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (stall_chk) begin
                    check_w("stall_data", tdata, held_data);
                    check_w("stall_ctl", DW'({tvalid, tlast, tkeep}), DW'({1'b1, held_last, held_keep}));
                end
                if (tvalid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    stall_chk = !tready;
                    held_data = tdata;
                    held_keep = tkeep;
                    held_last = tlast;
                    if (tready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_beat: got data %h with no beat expected", tdata);
                        end else begin
                            e = exp_q.pop_front();
                            for (int k = 0; k < KW; k++) m[8*k +: 8] = {8{e.keep[k]}};
                            check_w("beat_data", tdata & m, e.data & m);
                            check_w("beat_keep", DW'(tkeep), DW'(e.keep));
                            check_w("beat_last", DW'(tlast), DW'(e.last));
                        end
                    end
                end else begin
                    stall_chk = 1'b0;
                end
            end
        end
    end

    // reference: output byte i is byte (i mod rate) of block (i / rate), cut into 32-byte beats
    task automatic prepare(input int mode, input int len);
        int rate;
        int nblk;
        int cnt;
        logic [1599:0] b;
        beat_t e;
        rate = (mode == 0) ? 136 : (mode == 1) ? 72 : (mode == 2) ? 168 : 136;
        exp_olen = (mode == 0) ? 32 : (mode == 1) ? 64 : len;
        nblk = exp_olen / rate + 2;
        blocks.delete();
        exp_q.delete();
        for (int i = 0; i < nblk; i++) begin
            for (int j = 0; j < 50; j++) b[32*j +: 32] = $urandom;
            blocks.push_back(b);
        end
        blk_idx = 0;
        state_i = blocks[0];
        e.data = '0;
        e.keep = '0;
        e.last = 1'b0;
        cnt = 0;
        for (int i = 0; i < exp_olen; i++) begin
            b = blocks[i / rate];
            e.data[8*cnt +: 8] = b[8*(i % rate) +: 8];
            e.keep[cnt] = 1'b1;
            cnt++;
            if (cnt == KW || i == exp_olen - 1) begin
                e.last = (i == exp_olen - 1);
                exp_q.push_back(e);
                e.data = '0;
                e.keep = '0;
                e.last = 1'b0;
                cnt = 0;
            end
        end
        exp_perms = (exp_olen == 0 || mode < 2) ? 0 : (exp_olen + rate - 1) / rate - 1;
        perm_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
    endtask

    task automatic do_start(input int mode, input int len);
        @(posedge clk);
        #1;
        mode_i = 2'(mode);
        out_len_i = LW'(len);
        start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        mode_i = 2'($urandom);
        out_len_i = LW'($urandom);
    endtask

    task automatic wait_done_and_check(input bit chk_lat);
        for (int t = 0; t < 5000 && done_cnt == 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_i("done_count", done_cnt, 1);
        check_i("perm_count", perm_cnt, exp_perms);
        check_i("beats_left", exp_q.size(), 0);
        check_i("busy_after", int'(busy), 0);
        if (exp_olen == 0)
            check_i("len0_done_latency", done_cyc - start_cyc, 1);
        else if (chk_lat)
            check_i("first_valid_latency", first_valid_cyc - start_cyc, 2);
        exp_q.delete();
    endtask

    task automatic run_stream(input int mode, input int len, input int rmode);
        ready_mode = rmode;
        prepare(mode, len);
        do_start(mode, len);
        wait_done_and_check(1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_w("reset_data", tdata, '0);
        check_w("reset_ctl", DW'({tvalid, tlast, tkeep, busy, done, perm_req}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_stream(0, 0, 0);      // SHA3_256, ready high
        run_stream(1, 0, 1);      // SHA3_512, toggling ready
        run_stream(2, 200, 1);    // SHAKE128 200 bytes, one block crossing mid-beat
        run_stream(3, 272, 2);    // SHAKE256 272 bytes, ends exactly at the rate
        run_stream(3, 0, 0);      // SHAKE256 zero length

        // reset while waiting for a permutation
        ready_mode = 0;
        perm_auto = 1'b0;
        prepare(2, 400);
        do_start(2, 400);
        for (int t = 0; t < 500 && perm_cnt == 0; t++) @(posedge clk);
        check_i("perm_seen_before_reset", perm_cnt, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_w("after_rst_ctl", DW'({tvalid, busy, done}), '0);
        exp_q.delete();
        @(posedge clk);
        #1;
        perm_done_i = 1'b1;
        @(posedge clk);
        #1;
        perm_done_i = 1'b0;
        repeat (2) @(negedge clk);
        check_w("late_perm_done_ignored", DW'({tvalid, busy, done}), '0);
        check_i("no_done_after_rst", done_cnt, 0);
        perm_auto = 1'b1;

        // SHA3_256 after reset, with a start pulse while the beat is stalled
        ready_mode = 3;
        prepare(0, 0);
        do_start(0, 0);
        for (int t = 0; t < 50 && !tvalid; t++) @(negedge clk);
        check_i("valid_while_stalled", int'(tvalid), 1);
        @(posedge clk);
        #1;
        mode_i = 2'd2;
        out_len_i = LW'(100);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        ready_mode = 0;
        wait_done_and_check(1'b0);

        for (int r = 0; r < 10; r++)
            run_stream(int'($urandom_range(0, 3)), int'($urandom_range(1, 600)), int'($urandom_range(0, 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
